// File: rtl/rgb_fader_if.sv
// rgb_fader_if -- control/status bundle of the breathing-colour sequencer.
//   en, restart             : run enable and synchronous restart pulse (into the fader)
//   r_val, g_val, b_val     : 8-bit duty values for the PWM/RGB driver (out of the fader)
//   colour                  : active channel 0=red 1=green 2=blue
//   cycle_done              : one-cycle pulse when colour wraps blue -> red
// master = controller/testbench side, slave = rgb_fader side.
interface rgb_fader_if;
    logic       en;
    logic       restart;
    logic [7:0] r_val;
    logic [7:0] g_val;
    logic [7:0] b_val;
    logic [1:0] colour;
    logic       cycle_done;

    modport master (
        output en, restart,
        input  r_val, g_val, b_val, colour, cycle_done
    );

    modport slave (
        input  en, restart,
        output r_val, g_val, b_val, colour, cycle_done
    );
endinterface

// File: rtl/rgb_fader.sv
// rgb_fader -- breathing-colour sequencer. Ramps one channel 0->255, holds it
// for HOLD_STEPS steps, ramps it back to 0, then advances red->green->blue.
// One fade step every STEP_DIV clocks while en is high.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rgb_fader_if.slave (en, restart in; duty values, colour,
//                cycle_done out). All outputs are registered.
// Optional: define RGB_FADER_GAMMA_EN for duty(L) = (L*(L+2)) >> 8,
// otherwise duty(L) = L.
module rgb_fader #(
    parameter int STEP_DIV   = 12000,
    parameter int HOLD_STEPS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    rgb_fader_if.slave  bus
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {RISE, HOLD, FALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    lvl_q, lvl_d;
    logic [1:0]    col_q, col_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          done_q, done_d;
    logic          tick;
    logic [7:0]    duty_d;

    function automatic logic [7:0] duty(input logic [7:0] l);
`ifdef RGB_FADER_GAMMA_EN
        logic [15:0] sq;
        // 255*257 = 65535, so 16 bits never overflow and both endpoints stay exact.
        sq = {8'd0, l} * ({8'd0, l} + 16'd2);
        return sq[15:8];
`else
        return l;
`endif
    endfunction

    assign tick = bus.en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        lvl_d   = lvl_q;
        hold_d  = hold_q;
        col_d   = col_q;
        done_d  = 1'b0;
        if (bus.restart) begin
            cnt_d   = '0;
            state_d = RISE;
            lvl_d   = 8'd0;
            hold_d  = '0;
            col_d   = 2'd0;
        end else if (bus.en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                case (state_q)
                    RISE: begin
                        lvl_d = lvl_q + 8'd1;
                        if (lvl_q == 8'd254) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end
                    end
                    HOLD: begin
                        hold_d = hold_q + HW'(1);
                        if (hold_q == HOLD_LAST) state_d = FALL;
                    end
                    FALL: begin
                        lvl_d = lvl_q - 8'd1;
                        if (lvl_q == 8'd1) begin
                            state_d = RISE;
                            col_d   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                            done_d  = (col_q == 2'd2);
                        end
                    end
                    default: state_d = RISE;
                endcase
            end
        end
        // Outputs are built from next-state values so colour and duty land on
        // the same edge; a paused fader recomputes identical values.
        duty_d = duty(lvl_d);
        r_d    = (col_d == 2'd0) ? duty_d : 8'd0;
        g_d    = (col_d == 2'd1) ? duty_d : 8'd0;
        b_d    = (col_d == 2'd2) ? duty_d : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RISE;
            cnt_q   <= '0;
            hold_q  <= '0;
            lvl_q   <= 8'd0;
            col_q   <= 2'd0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            lvl_q   <= lvl_d;
            col_q   <= col_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    assign bus.r_val      = r_q;
    assign bus.g_val      = g_q;
    assign bus.b_val      = b_q;
    assign bus.colour     = col_q;
    assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader -- self-checking bench for rgb_fader (STEP_DIV=4, HOLD_STEPS=2).
// Reference model: counts enabled cycles since reset/restart; the step number
// is that count / STEP_DIV and the expected colour/level follow from the
// step number with plain arithmetic over the 512-step colour period.
module tb_rgb_fader;
    localparam int SD  = 4;
    localparam int H   = 2;
    localparam int PER = 510 + H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    rgb_fader_if bus ();

    rgb_fader #(.STEP_DIV(SD), .HOLD_STEPS(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---- reference model ----
    int en_cnt;
    bit tick_edge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt    <= 0;
            tick_edge <= 1'b0;
        end else if (bus.restart) begin
            en_cnt    <= 0;
            tick_edge <= 1'b0;
        end else if (bus.en) begin
            en_cnt    <= en_cnt + 1;
            tick_edge <= ((en_cnt + 1) % SD) == 0;
        end else begin
            tick_edge <= 1'b0;
        end
    end

    function automatic int duty_ref(input int l);
`ifdef RGB_FADER_GAMMA_EN
        return (l * (l + 2)) >> 8;
`else
        return l;
`endif
    endfunction

    // {colour, r, g, b, cycle_done}
    function automatic logic [26:0] exp_vec();
        int t, pos, col, l, d;
        logic [7:0] r, g, b;
        logic cd;
        t   = en_cnt / SD;
        pos = t % PER;
        col = (t / PER) % 3;
        if (pos <= 255)          l = pos;
        else if (pos <= 255 + H) l = 255;
        else                     l = 255 - (pos - 255 - H);
        d  = duty_ref(l);
        r  = (col == 0) ? 8'(d) : 8'd0;
        g  = (col == 1) ? 8'(d) : 8'd0;
        b  = (col == 2) ? 8'(d) : 8'd0;
        cd = tick_edge && (t > 0) && (t % (3 * PER) == 0);
        return {2'(col), r, g, b, cd};
    endfunction

    function automatic logic [26:0] act_vec();
        return {bus.colour, bus.r_val, bus.g_val, bus.b_val, bus.cycle_done};
    endfunction

    task automatic pulse_restart();
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (act_vec() !== 27'd0) begin
            errs++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), 27'd0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== 27'd0) begin
                errs++;
                $display("FAIL first_step_idle c%0d: got %h expected %h", i, act_vec(), 27'd0);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.r_val !== 8'd1 || bus.g_val !== 8'd0 || bus.b_val !== 8'd0) begin
            errs++;
            $display("FAIL first_step: got r=%0d g=%0d b=%0d expected r=1 g=0 b=0",
                     bus.r_val, bus.g_val, bus.b_val);
        end
    endtask

    task automatic test_full_period();
        int hold_cyc = 0;
        int bad = 0;
        pulse_restart();
        for (int i = 0; i < SD * PER; i++) begin
            @(negedge clk);
            if (bus.r_val == 8'd255) hold_cyc++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++;
                if (bad++ < 5)
                    $display("FAIL period_trace c%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (hold_cyc != SD * (H + 1)) begin
            errs++;
            $display("FAIL full_hold_time: got %0d expected %0d", hold_cyc, SD * (H + 1));
        end
        checks++;
        if (bus.colour !== 2'd1 || bus.r_val !== 8'd0) begin
            errs++;
            $display("FAIL colour_advance: got colour=%0d r=%0d expected colour=1 r=0", bus.colour, bus.r_val);
        end
        repeat (SD) @(negedge clk);
        checks++;
        if (bus.g_val !== 8'd1 || bus.r_val !== 8'd0) begin
            errs++;
            $display("FAIL green_first_step: got g=%0d r=%0d expected g=1 r=0", bus.g_val, bus.r_val);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        int bad = 0;
        logic [1:0] prev_col;
        pulse_restart();
        prev_col = bus.colour;
        for (int i = 0; i < 3 * SD * PER + SD; i++) begin
            @(negedge clk);
            if (bus.cycle_done === 1'b1) begin
                pulses++;
                checks++;
                if (prev_col !== 2'd2 || bus.colour !== 2'd0) begin
                    errs++;
                    $display("FAIL wrap_coincide: got %0d->%0d expected 2->0", prev_col, bus.colour);
                end
            end
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++;
                if (bad++ < 5)
                    $display("FAIL wrap_trace c%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            prev_col = bus.colour;
        end
        checks++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL cycle_done_count: got %0d expected 1", pulses);
        end
        checks++;
        if (bus.r_val !== 8'd1) begin
            errs++;
            $display("FAIL red_after_wrap: got %0d expected 1", bus.r_val);
        end
    endtask

    task automatic test_pause();
        int n = 0;
        bit found = 0;
        pulse_restart();
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (bus.r_val == 8'd40) found = 1;
        end
        checks++;
        if (!found) begin
            errs++;
            $display("FAIL pause_reach40: got r=%0d expected 40 within bound", bus.r_val);
        end
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (bus.r_val !== 8'd40 || act_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL pause_hold c%0d: got r=%0d expected 40", i, bus.r_val);
            end
        end
        bus.en = 1'b1;
        found = 0;
        while (n < 10 && !found) begin
            @(negedge clk);
            n++;
            if (bus.r_val == 8'd41) found = 1;
        end
        checks++;
        if (!found || n != SD - 1) begin
            errs++;
            $display("FAIL pause_resume_latency: got %0d expected %0d", n, SD - 1);
        end
    endtask

    task automatic test_restart_collision();
        bit seen_top = 0;
        bit found = 0;
        pulse_restart();
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            if (bus.colour == 2'd2 && bus.b_val == 8'd255) seen_top = 1;
            if (seen_top && bus.colour == 2'd2 && bus.b_val == 8'd90) found = 1;
        end
        checks++;
        if (!found) begin
            errs++;
            $display("FAIL collision_reach90: got b=%0d expected 90 within bound", bus.b_val);
        end
        repeat (SD - 1) @(negedge clk);
        // next edge is the tick edge of this step
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        checks++;
        if (act_vec() !== 27'd0) begin
            errs++;
            $display("FAIL collision_clear: got %h expected %h", act_vec(), 27'd0);
        end
        for (int i = 1; i <= SD; i++) begin
            @(negedge clk);
            checks++;
            if (bus.r_val !== ((i == SD) ? 8'd1 : 8'd0)) begin
                errs++;
                $display("FAIL collision_first_step c%0d: got %0d expected %0d", i, bus.r_val, (i == SD) ? 1 : 0);
            end
        end
    endtask

    task automatic test_levels();
        logic [7:0] e16, e128, e255;
`ifdef RGB_FADER_GAMMA_EN
        e16 = 8'd1; e128 = 8'd65; e255 = 8'd255;
`else
        e16 = 8'd16; e128 = 8'd128; e255 = 8'd255;
`endif
        pulse_restart();
        repeat (16 * SD) @(negedge clk);
        checks++;
        if (bus.r_val !== e16) begin
            errs++;
            $display("FAIL level16: got %0d expected %0d", bus.r_val, e16);
        end
        repeat (112 * SD) @(negedge clk);
        checks++;
        if (bus.r_val !== e128) begin
            errs++;
            $display("FAIL level128: got %0d expected %0d", bus.r_val, e128);
        end
        repeat (127 * SD) @(negedge clk);
        checks++;
        if (bus.r_val !== e255) begin
            errs++;
            $display("FAIL level255: got %0d expected %0d", bus.r_val, e255);
        end
    endtask

    task automatic test_async_reset();
        pulse_restart();
        repeat (50 * SD + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 27'd0) begin
            errs++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), 27'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SD) @(negedge clk);
        checks++;
        if (bus.r_val !== 8'd1 || bus.colour !== 2'd0) begin
            errs++;
            $display("FAIL post_reset_step: got r=%0d colour=%0d expected r=1 colour=0", bus.r_val, bus.colour);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++;
                if (bad++ < 5)
                    $display("FAIL random_trace c%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            bus.en      = ($urandom_range(0, 9) < 8);
            bus.restart = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        bus.en = 1'b1;
        bus.restart = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.restart = 1'b0;
        test_reset();
        test_full_period();
        test_wrap();
        test_pause();
        test_restart_collision();
        test_levels();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
